// File: rtl/seg7_readback.sv
// ---------------------------------------------------------------------------
// seg7_readback
//   Reads back the multiplexed, active-low seven-segment bus of the lab
//   adder/subtracter display. Each digit slot is debounced separately. Once
//   all four slots are stable and legal, one decoded frame is presented
//   together with an arithmetic consistency check.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   seg_in     active-low segments, bit0=a .. bit6=g
//   dig_sel    slot id: 0=result, 1=sign/carry, 2=operand B, 3=operand A
//   seg_strobe seg_in/dig_sel valid this cycle
//   out_ready  consumer accepts the frame
//   out_valid  frame available (held until accepted)
//   num_a      decoded operand A
//   num_b      decoded operand B
//   mag        decoded result digit
//   neg        sign glyph was '-'
//   carry      sign glyph was '1'
//   add_ok     frame consistent with A+B
//   sub_ok     frame consistent with A-B
//   err_pulse  one-cycle flag, illegal pattern received on the previous cycle
// ---------------------------------------------------------------------------
module seg7_readback #(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic [1:0] dig_sel,
    input  logic       seg_strobe,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] num_a,
    output logic [3:0] num_b,
    output logic [3:0] mag,
    output logic       neg,
    output logic       carry,
    output logic       add_ok,
    output logic       sub_ok,
    output logic       err_pulse
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

    // Returns {legal, value}; only the sixteen exact glyphs are accepted.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'h40: return {1'b1, 4'h0};
            7'h79: return {1'b1, 4'h1};
            7'h24: return {1'b1, 4'h2};
            7'h30: return {1'b1, 4'h3};
            7'h19: return {1'b1, 4'h4};
            7'h12: return {1'b1, 4'h5};
            7'h02: return {1'b1, 4'h6};
            7'h78: return {1'b1, 4'h7};
            7'h00: return {1'b1, 4'h8};
            7'h10: return {1'b1, 4'h9};
            7'h08: return {1'b1, 4'hA};
            7'h03: return {1'b1, 4'hB};
            7'h46: return {1'b1, 4'hC};
            7'h21: return {1'b1, 4'hD};
            7'h06: return {1'b1, 4'hE};
            7'h0E: return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    // Returns {legal, neg, carry} for the sign/carry slot.
    function automatic logic [2:0] sign_decode(input logic [6:0] p);
        case (p)
            7'h7F: return 3'b100;
            7'h3F: return 3'b110;
            7'h79: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic pat_legal(input logic [1:0] slot, input logic [6:0] p);
        logic [4:0] h;
        logic [2:0] s;
        h = hex_decode(p);
        s = sign_decode(p);
        return (slot == 2'd1) ? s[2] : h[4];
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       pat_q [4];
    logic [6:0]       pat_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       lock_d;
    logic             accept;
    logic             latch_en;

    assign accept = (state_q == HOLD) && out_ready;

    // Tracker next state. Lock is derived from the *next* counter/pattern so
    // the frame can be latched on the same edge as the completing strobe.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            pat_d[i] = pat_q[i];
            cnt_d[i] = accept ? '0 : cnt_q[i];
            if (seg_strobe && dig_sel == 2'(i)) begin
                // On acceptance the strobe is the first sample of the new frame.
                if (!accept && seg_in == pat_q[i]) begin
                    cnt_d[i] = (cnt_q[i] >= STABLE) ? STABLE : cnt_q[i] + 1'b1;
                end else begin
                    pat_d[i] = seg_in;
                    cnt_d[i] = CNT_W'(1);
                end
            end
            lock_d[i] = (cnt_d[i] == STABLE) && pat_legal(2'(i), pat_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the four pattern/count entries are plain flops, not RAM, so they are reset like any register.
            for (int i = 0; i < 4; i++) begin
                pat_q[i] <= 7'h7F;
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < 4; i++) begin
                pat_q[i] <= pat_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Decoded view of the next tracker contents, plus the arithmetic check.
    logic [4:0] dec_a, dec_b, dec_m;
    logic [2:0] dec_s;
    logic [4:0] sum_ab;
    logic       add_ok_d, sub_ok_d;

    always_comb begin
        dec_a    = hex_decode(pat_d[3]);
        dec_b    = hex_decode(pat_d[2]);
        dec_m    = hex_decode(pat_d[0]);
        dec_s    = sign_decode(pat_d[1]);
        sum_ab   = {1'b0, dec_a[3:0]} + {1'b0, dec_b[3:0]};
        add_ok_d = !dec_s[1] && ({dec_s[0], dec_m[3:0]} == sum_ab);
        if (dec_a[3:0] >= dec_b[3:0])
            sub_ok_d = !dec_s[0] && !dec_s[1] && (dec_m[3:0] == dec_a[3:0] - dec_b[3:0]);
        else
            sub_ok_d = !dec_s[0] && dec_s[1] && (dec_m[3:0] == dec_b[3:0] - dec_a[3:0]);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (&lock_d)   state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default:                state_d = COLLECT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        latch_en  = (state_q == COLLECT) && (&lock_d);
        out_valid = (state_q == HOLD);
    end

    // Frame registers: loaded once per frame, frozen while it is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_a  <= '0;
            num_b  <= '0;
            mag    <= '0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            add_ok <= 1'b0;
            sub_ok <= 1'b0;
        end else if (latch_en) begin
            num_a  <= dec_a[3:0];
            num_b  <= dec_b[3:0];
            mag    <= dec_m[3:0];
            neg    <= dec_s[1];
            carry  <= dec_s[0];
            add_ok <= add_ok_d;
            sub_ok <= sub_ok_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_pulse <= 1'b0;
        else        err_pulse <= seg_strobe && !pat_legal(dig_sel, seg_in);
    end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Reader for the multiplexed seven-segment bus driven by the lab adder/subtracter display path. Samples active-low segment patterns per digit slot, debounces each slot, decodes hex digits and the sign/carry glyph, then presents one complete frame.
- Each frame carries operand A, operand B, result magnitude, negative flag and carry flag.
- Also checks the frame for arithmetic consistency.
- Used as a self-check/readback monitor between the display driver and the board pins.

Parameters:
- STABLE_CNT, 3: consecutive identical strobed samples needed to lock a slot. Legal range 1..15.
- CNT_W, 4: width of the per-slot stability counter. Must hold STABLE_CNT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- seg_in  input  7  active-low segments; bit0=a .. bit6=g
- dig_sel  input  2  slot id: 0=result digit, 1=sign/carry digit, 2=operand B, 3=operand A
- seg_strobe  input  1  seg_in/dig_sel valid this cycle
- out_ready  input  1  consumer accepts frame
- out_valid  output  1  frame available
- num_a  output  4  decoded operand A
- num_b  output  4  decoded operand B
- mag  output  4  decoded result digit
- neg  output  1  sign glyph was '-'
- carry  output  1  sign glyph was '1'
- add_ok  output  1  frame consistent with A+B
- sub_ok  output  1  frame consistent with A-B
- err_pulse  output  1  one-cycle flag: illegal pattern received

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, FSM=COLLECT, every slot unlocked, stability counters 0, stored patterns 7'h7F. Reset mid-frame discards all partial state.

Hex decode (active-low, exact match only):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Any other pattern on slots 0/2/3 is illegal.

Sign decode, slot 1:
- 7F = blank (neg=0, carry=0)
- 3F = '-' (neg=1)
- 79 = '1' (carry=1)
- Anything else is illegal.

Per-slot tracker, updated only on seg_strobe for the addressed slot:
- Pattern equals stored pattern: counter saturates at STABLE_CNT.
- Otherwise: store the new pattern, counter=1, unlock the slot.
- A slot locks when its counter reaches STABLE_CNT with a legal pattern.
- An illegal pattern never locks. It raises err_pulse on the next cycle and still resets that slot's counter.
- STABLE_CNT=1: a single legal strobe locks the slot.

FSM COLLECT:
- When all four slots are locked, latch the decoded values into the output registers and move to HOLD.
- out_valid=1 in the cycle after the strobe that completes the set (latency 1 clock).

FSM HOLD:
- Output registers are frozen while out_valid=1.
- Strobes continue to update the trackers.
- A locked slot that changes unlocks, but this does not alter the held frame.
- On out_valid & out_ready: out_valid drops next cycle, all lock flags and counters clear, FSM returns to COLLECT.
- A strobe in the same cycle as acceptance counts as the first sample (count=1) of the new frame.

Consistency check, computed combinationally from the latched values and registered with the frame:
- add_ok = (neg==0) && ({carry,mag} == A+B as a 5-bit sum).
- sub_ok = (carry==0) && (A>=B ? (neg==0 && mag==A-B) : (neg==1 && mag==B-A)).
- Both may be 1, e.g. when B=0.

Other rules:
- Strobes with seg_in held constant across slots are allowed; each slot is tracked independently.
- Back-to-back strobes every cycle are supported with no bubbles.

Test Plan:
- STABLE_CNT=3; strobe slots 3,2,1,0 three times each with A=5(12), B=3(30), sign 7F, result 8(00) -> out_valid=1 one cycle after the 12th strobe; num_a=5, num_b=3, mag=8, neg=0, carry=0, add_ok=1, sub_ok=0.
- A=9(10), B=C(46), sign 79, result 5(12), stable -> carry=1, mag=5, add_ok=1 (9+12=21); hold out_ready=0 for 10 cycles with changing strobes -> outputs frozen; out_ready=1 -> out_valid=0 next cycle.
- A=2(24), B=7(78), sign 3F, result 5(12) -> neg=1, sub_ok=1, add_ok=0.
- Slot 2 receives 24,24,30,30,30 -> locks only after the third 30; num_b=3, not 2.
- Slot 0 receives 7'h55 -> err_pulse=1 for exactly one cycle, no frame produced; then legal 40 ×3 -> frame completes with mag=0.
- rst_n=0 for one cycle after 3 of 4 slots are locked -> all outputs 0; the frame requires full re-collection of all four slots.
